cpu_mem: RTL
============

# cpu_mem

Memory-access pipeline stage, directly downstream of the execute stage. It registers EX results in the EX/MEM boundary and performs the LW/SW data-bus transaction with a req/ack handshake. It checks word alignment and raises the address-error exceptions, and presents register, HI/LO and CP0 write requests to write-back. The same requests are also forwarded back to EX for bypassing, and the stage stalls the pipeline while a bus access is outstanding.

## Interface
- No parameters; widths come from `cpu_defs` types.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard the held instruction (exception/ERET commit)
- ex_valid  in  1  EX presents an instruction this cycle
- ex_reg_wr  in  RegWriteReq_t  GPR write request; wdata = EX `ret`
- ex_memory_req  in  MemAccessReq_t  ce/we/addr/wdata/sel from EX
- ex_hilo_wr  in  HiloWriteReq_t  HI/LO write request
- ex_cp0_reg_wr  in  RegWriteReq_t  CP0 write request
- ex_except  in  ExceptInfo_t  exception already raised upstream
- accept  out  1  stage captures EX inputs at this clock edge
- stall_req  out  1  pipeline must hold upstream stages
- dbus_req  out  1  data-bus request
- dbus_we  out  1  1 = store
- dbus_addr  out  32  word address (bits [1:0] = 0)
- dbus_wdata  out  32  store data
- dbus_sel  out  4  byte enables
- dbus_ack  in  1  transaction complete; rdata valid same cycle
- dbus_rdata  in  32  load data
- mem_valid  out  1  result valid to WB this cycle
- mem_reg_wr  out  RegWriteReq_t  to WB and EX/ID bypass
- mem_hilo_wr  out  HiloWriteReq_t  to WB and EX bypass
- mem_cp0_reg_wr  out  RegWriteReq_t  to WB and EX bypass
- mem_except  out  ExceptInfo_t  final exception info
- mem_badvaddr  out  32  faulting address for AdEL/AdES

## Operation
- States: IDLE, BUS, DRAIN.
- IDLE with a held instruction:
  - Not a memory op, or faulting: results valid immediately.
  - Aligned memory op with no exception: move to BUS.
- Capture: `accept` = (state == IDLE) && !(held memory op not yet complete). Registers load the `ex_*` inputs; if ex_valid = 0 the held slot becomes a bubble.
- Alignment: ce && addr[1:0] != 0 → `except.occur` = 1, code `EXCCODE_ADEL` (load) or `EXCCODE_ADES` (store), badvaddr = addr, no bus access.
- Upstream exception (ex_except.occur) passes through unchanged; no bus access.
- Whenever `mem_except.occur` = 1, reg/hilo/cp0 `we` are forced to 0.
- BUS state:
  - dbus_req held high with stable addr/wdata/sel/we until dbus_ack.
  - On ack: load data latched into mem_reg_wr.wdata (LW only), then → IDLE with result valid.
- Flush:
  - IDLE: the held slot is cleared to a bubble at the edge.
  - BUS without ack: → DRAIN. dbus_req stays high until ack; ack data is discarded; no writes and no mem_valid.
  - BUS with ack in the same cycle: transaction dropped, → IDLE.
  - DRAIN → IDLE on ack.
- stall_req = (state ∈ {BUS, DRAIN}) && !dbus_ack. It also covers the IDLE cycle in which a memory op is just captured and will enter BUS.

## Timing
- Reset: state IDLE, held slot bubble. All outputs 0: dbus_req, mem_valid, all `we` bits, except.occur, badvaddr.
- Non-memory instruction: captured at edge N, mem_valid in cycle N+1.
- LW/SW: captured at edge N, dbus_req first high in cycle N+1. Ack in cycle K gives mem_valid in cycle K+1. Minimum latency is 2 cycles.
- One outstanding bus transaction at most; ack outside BUS/DRAIN is ignored.
- rst mid-transaction drops dbus_req next cycle. The bus slave is reset by the same rst.

## Structure
- Add to the `cpu_defs` package:
  - `MemState_t` enum (IDLE/BUS/DRAIN)
  - `DbusReq_t` struct (req, we, addr, wdata, sel)
  - `EXCCODE_ADEL` = 5'h04 and `EXCCODE_ADES` = 5'h05
- Sub-module `mem_dbus_ctrl` holds the FSM and handshake. The top holds the EX/MEM registers, the alignment check and the output muxing.

## Test plan
- ORI result 0x1234 with rd = 5, ex_valid → next cycle mem_valid = 1, mem_reg_wr = {we 1, waddr 5, wdata 0x1234}; no dbus_req.
- LW addr 0x80000010, slave acks 3 cycles after req with rdata 0xDEADBEEF → dbus_req high 3 cycles, stall_req high until the ack cycle, then wdata = 0xDEADBEEF.
- SW addr 0x80000012 → no dbus_req, mem_except = {occur 1, code 5}, badvaddr 0x80000012, reg we = 0.
- LW in BUS, flush before ack, ack 2 cycles later → dbus_req held until ack, no mem_valid, state returns to IDLE.
- MTC0 with ex_except.occur = 1 → cp0 we = 0, except passed through, no bus traffic.
- rst asserted mid-BUS → next cycle dbus_req = 0, mem_valid = 0, accept = 1.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared CPU datapath types plus the memory-stage additions.
package cpu_defs;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } RegWriteReq_t;

  typedef struct packed {
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } MemAccessReq_t;

  typedef struct packed {
    logic        we;
    logic [31:0] hi;
    logic [31:0] lo;
  } HiloWriteReq_t;

  typedef struct packed {
    logic        occur;
    logic        eret;
    logic [4:0]  code;
    logic [31:0] pc;
  } ExceptInfo_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    DRAIN = 2'd2
  } MemState_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } DbusReq_t;

  localparam logic [4:0] EXCCODE_ADEL = 5'h04;
  localparam logic [4:0] EXCCODE_ADES = 5'h05;

  function automatic logic word_aligned(input logic [1:0] addr_lo);
    return addr_lo == 2'b00;
  endfunction

endpackage

// File: rtl/cpu_mem_if.sv
// Data-bus req/ack channel between the memory stage and the bus slave.
interface cpu_mem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, sel, input ack, rdata);
  modport slave  (input req, we, addr, wdata, sel, output ack, rdata);
endinterface

// File: rtl/cpu_mem_dbus_ctrl.sv
// Data-bus FSM: holds one request stable until ack, drains it on flush.
module mem_dbus_ctrl
  import cpu_defs::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      start,
  input  DbusReq_t  req_in,
  output logic      idle,
  output logic      busy,
  output logic      done,
  cpu_mem_if.master dbus
);

  MemState_t state_q, state_d;
  DbusReq_t  dbus_q, dbus_d;

  // Next state, held request and completion strobe
  always_comb begin
    state_d = state_q;
    dbus_d  = dbus_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = BUS;
          dbus_d     = req_in;
          dbus_d.req = 1'b1;
        end
      end
      BUS: begin
        if (dbus.ack) begin
          state_d    = IDLE;
          dbus_d.req = 1'b0;
          done       = !flush;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dbus.ack) begin
          state_d    = IDLE;
          dbus_d.req = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        dbus_d  = '0;
      end
    endcase
  end

  // State and request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dbus_q  <= '0;
    end else begin
      state_q <= state_d;
      dbus_q  <= dbus_d;
    end
  end

  assign dbus.req   = dbus_q.req;
  assign dbus.we    = dbus_q.we;
  assign dbus.addr  = dbus_q.addr;
  assign dbus.wdata = dbus_q.wdata;
  assign dbus.sel   = dbus_q.sel;

  assign idle = (state_q == IDLE);
  assign busy = ((state_q == BUS) || (state_q == DRAIN)) && !dbus.ack;

endmodule

// File: rtl/cpu_mem.sv
// Memory stage: EX/MEM slot, alignment exceptions, LW/SW bus access, WB/bypass outputs.
module cpu_mem
  import cpu_defs::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          ex_valid,
  input  RegWriteReq_t  ex_reg_wr,
  input  MemAccessReq_t ex_memory_req,
  input  HiloWriteReq_t ex_hilo_wr,
  input  RegWriteReq_t  ex_cp0_reg_wr,
  input  ExceptInfo_t   ex_except,
  output logic          accept,
  output logic          stall_req,
  cpu_mem_if.master     dbus,
  output logic          mem_valid,
  output RegWriteReq_t  mem_reg_wr,
  output HiloWriteReq_t mem_hilo_wr,
  output RegWriteReq_t  mem_cp0_reg_wr,
  output ExceptInfo_t   mem_except,
  output logic [31:0]   mem_badvaddr
);

  logic          valid_q, valid_d;
  RegWriteReq_t  reg_wr_q, reg_wr_d;
  HiloWriteReq_t hilo_q, hilo_d;
  RegWriteReq_t  cp0_q, cp0_d;
  ExceptInfo_t   except_q, except_d;
  logic [31:0]   badvaddr_q, badvaddr_d;
  logic          load_q, load_d;

  logic     misalign, start, idle, busy, done, wr_ok;
  DbusReq_t bus_req;

  // Classify the incoming EX instruction and build its bus request
  always_comb begin
    misalign = ex_memory_req.ce && !word_aligned(ex_memory_req.addr[1:0]);
    start    = idle && ex_valid && !flush && ex_memory_req.ce &&
               !misalign && !ex_except.occur;
    bus_req  = '{req:   1'b1,
                 we:    ex_memory_req.we,
                 addr:  {ex_memory_req.addr[31:2], 2'b00},
                 wdata: ex_memory_req.wdata,
                 sel:   ex_memory_req.sel};
  end

  // EX/MEM slot: capture in IDLE, bubble on flush, load data on ack
  always_comb begin
    valid_d    = valid_q;
    reg_wr_d   = reg_wr_q;
    hilo_d     = hilo_q;
    cp0_d      = cp0_q;
    except_d   = except_q;
    badvaddr_d = badvaddr_q;
    load_d     = load_q;
    if (idle) begin
      if (flush || !ex_valid) begin
        valid_d    = 1'b0;
        reg_wr_d   = '0;
        hilo_d     = '0;
        cp0_d      = '0;
        except_d   = '0;
        badvaddr_d = '0;
        load_d     = 1'b0;
      end else begin
        valid_d    = 1'b1;
        reg_wr_d   = ex_reg_wr;
        hilo_d     = ex_hilo_wr;
        cp0_d      = ex_cp0_reg_wr;
        except_d   = ex_except;
        badvaddr_d = '0;
        load_d     = ex_memory_req.ce && !ex_memory_req.we;
        if (!ex_except.occur && misalign) begin
          except_d.occur = 1'b1;
          except_d.code  = ex_memory_req.we ? EXCCODE_ADES : EXCCODE_ADEL;
          badvaddr_d     = ex_memory_req.addr;
        end
      end
    end else if (flush) begin
      // The bus request lives in the controller, so the slot can be
      // dropped here while an outstanding access still drains.
      valid_d    = 1'b0;
      reg_wr_d   = '0;
      hilo_d     = '0;
      cp0_d      = '0;
      except_d   = '0;
      badvaddr_d = '0;
      load_d     = 1'b0;
    end else if (done && load_q) begin
      reg_wr_d.wdata = dbus.rdata;
    end
  end

  // EX/MEM slot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      reg_wr_q   <= '0;
      hilo_q     <= '0;
      cp0_q      <= '0;
      except_q   <= '0;
      badvaddr_q <= '0;
      load_q     <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      reg_wr_q   <= reg_wr_d;
      hilo_q     <= hilo_d;
      cp0_q      <= cp0_d;
      except_q   <= except_d;
      badvaddr_q <= badvaddr_d;
      load_q     <= load_d;
    end
  end

  mem_dbus_ctrl u_dbus_ctrl (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .start  (start),
    .req_in (bus_req),
    .idle   (idle),
    .busy   (busy),
    .done   (done),
    .dbus   (dbus)
  );

  // WB/bypass outputs; a faulting instruction never writes state
  always_comb begin
    accept         = idle;
    stall_req      = busy || start;
    mem_valid      = idle && valid_q;
    wr_ok          = mem_valid && !except_q.occur;
    mem_reg_wr     = reg_wr_q;
    mem_reg_wr.we  = reg_wr_q.we && wr_ok;
    mem_hilo_wr    = hilo_q;
    mem_hilo_wr.we = hilo_q.we && wr_ok;
    mem_cp0_reg_wr    = cp0_q;
    mem_cp0_reg_wr.we = cp0_q.we && wr_ok;
    mem_except     = mem_valid ? except_q : '0;
    mem_badvaddr   = mem_valid ? badvaddr_q : '0;
  end

endmodule
